// File: rtl/debounce_sync.sv
// Synchronizer chain plus debounce FSM with registered level, rise/fall pulses and busy flag.
// Optional glitch counter is compiled in when DEBOUNCE_GLITCH_CNT_EN is defined.
//
// state     | meaning
// STABLE_LO | dout=0, waiting for s to go high
// WAIT_HI   | s high, counting stable cycles before dout rises
// STABLE_HI | dout=1, waiting for s to go low
// WAIT_LO   | s low, counting stable cycles before dout falls
module debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 8,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic       clk,
    input  logic       Rs,
    input  logic       din,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_t           RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (Rs) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (Rs) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                // A revert, even in the last counting cycle, aborts the transition.
                if (!s) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_ev;
    logic [7:0] glitch_q;

    assign glitch_ev = ((state_q == WAIT_HI) && !s) || ((state_q == WAIT_LO) && s);

    always_ff @(posedge clk) begin
        if (Rs) begin
            glitch_q <= 8'd0;
        end else if (glitch_ev && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule
